// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM: sequences PC/IR/memory/regfile strobes and
// drives the 2-bit alu_op for the downstream ALU control decoder.
module mc_main_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ORI   = 6'b001101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       jr,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StRwb    = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StOriEx  = 4'd10,
        StOriWb  = 4'd11,
        StJreg   = 4'd12
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExec;
                    OP_BEQ:       state_d = StBranch;
                    OP_J:         state_d = StJump;
                    OP_ORI:       state_d = StOriEx;
                    default:      state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = (opcode == OP_SW) ? StMemWr : StMemRd;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWb:  state_d = StFetch;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StExec:   state_d = jr ? StJreg : StRwb;
            StRwb:    state_d = StFetch;
            StBranch: state_d = StFetch;
            StJump:   state_d = StFetch;
            StOriEx:  state_d = StOriWb;
            StOriWb:  state_d = StFetch;
            StJreg:   state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    logic opcode_known;
    assign opcode_known = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                          (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ORI);

    // Reset blanks every strobe combinationally so an aborted instruction leaks nothing.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        state         = 4'd0;
        if (!rst) begin
            state = state_q;
            case (state_q)
                StFetch: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                StDecode: begin
                    alu_src_b  = 2'b11;
                    illegal_op = ~opcode_known;
                end
                StMemAdr: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                StMemRd: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                StMemWb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                StMemWr: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                StExec: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                StRwb: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                StBranch: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                StJump: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                StOriEx: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b11;
                end
                StOriWb: begin
                    reg_write = 1'b1;
                end
                StJreg: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b11;
                end
                default: begin
                    state = state_q;
                end
            endcase
        end
    end

endmodule
